sequenciador_pc: RTL and testbench

Program-counter sequencer for the 8-bit processor: owns the current instruction address, drives the `pc` block's new-address input, and orders each instruction through fetch and execute. It handles sequential increment, taken branches, and call/return through a small internal return-address stack. It also handles halt. It sits between the instruction memory (fetch handshake) and the decoder (control flags).

---
 rtl/sequenciador_pc.sv | 143 ++++++++++++++
 tb/tb_sequenciador_pc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_pc.sv
// sequenciador_pc: program-counter sequencer for the 8-bit processor.
// Owns the current instruction address and steps each instruction through fetch
// (BUSCA) and execute (EXECUTA). It handles increment, branch, call/return
// through an internal return stack, and halt.
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   habilita           run enable
//   mem_pronta         instruction word at endAtual valid (BUSCA only)
//   desvio/chamada/
//   retorno/parar      decoder flags, sampled in EXECUTA only
//   end_alvo           branch/call target
//   novoEnd            combinational: next value of endAtual
//   endAtual           registered current instruction address
//   busca_req          fetch request (high in BUSCA)
//   estado             current state encoding
//   pilha_vazia/cheia  return stack empty / full
//   erro_pilha         sticky stack overflow/underflow
module sequenciador_pc #(
    parameter int unsigned LARGURA_END        = 8,
    parameter int unsigned PROFUNDIDADE_PILHA = 4,
    parameter logic [LARGURA_END-1:0] END_RESET = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   habilita,
    input  logic                   mem_pronta,
    input  logic                   desvio,
    input  logic                   chamada,
    input  logic                   retorno,
    input  logic                   parar,
    input  logic [LARGURA_END-1:0] end_alvo,
    output logic [LARGURA_END-1:0] novoEnd,
    output logic [LARGURA_END-1:0] endAtual,
    output logic                   busca_req,
    output logic [1:0]             estado,
    output logic                   pilha_vazia,
    output logic                   pilha_cheia,
    output logic                   erro_pilha
);

    // Pointer must represent 0..PROFUNDIDADE_PILHA inclusive.
    localparam int unsigned LARGURA_PP  = $clog2(PROFUNDIDADE_PILHA + 1);
    localparam int unsigned LARGURA_IDX = (PROFUNDIDADE_PILHA > 1) ? $clog2(PROFUNDIDADE_PILHA) : 1;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] BUSCA   = 2'd1;
    localparam logic [1:0] EXECUTA = 2'd2;
    localparam logic [1:0] PARADO  = 2'd3;

    logic [LARGURA_END-1:0] pilha [PROFUNDIDADE_PILHA];
    logic [LARGURA_PP-1:0]  ponteiro;

    logic [1:0]             estadoProx;
    logic [LARGURA_END-1:0] endProx;
    logic [LARGURA_END-1:0] endIncr;
    logic [LARGURA_PP-1:0]  ponteiroProx;
    logic                   erroProx;
    logic                   empilhar;
    logic                   vazia;
    logic                   cheia;
    logic [LARGURA_IDX-1:0] idxTopo;
    logic [LARGURA_IDX-1:0] idxPush;

    assign vazia   = (ponteiro == LARGURA_PP'(0));
    assign cheia   = (ponteiro == LARGURA_PP'(PROFUNDIDADE_PILHA));
    // Top entry sits one below the pointer; the index wraps harmlessly when empty.
    assign idxTopo = LARGURA_IDX'(ponteiro - LARGURA_PP'(1));
    assign idxPush = LARGURA_IDX'(ponteiro);
    assign endIncr = endAtual + LARGURA_END'(1);

    // Next-state, next-address and stack control.
    always_comb begin
        estadoProx   = estado;
        endProx      = endAtual;
        ponteiroProx = ponteiro;
        erroProx     = erro_pilha;
        empilhar     = 1'b0;
        case (estado)
            OCIOSO: begin
                if (habilita) estadoProx = BUSCA;
            end
            BUSCA: begin
                if (mem_pronta) estadoProx = EXECUTA;
            end
            EXECUTA: begin
                estadoProx = habilita ? BUSCA : OCIOSO;
                if (parar) begin
                    estadoProx = PARADO;
                end else if (retorno) begin
                    if (vazia) begin
                        erroProx   = 1'b1;
                        estadoProx = PARADO;
                    end else begin
                        ponteiroProx = ponteiro - LARGURA_PP'(1);
                        endProx      = pilha[idxTopo];
                    end
                end else if (chamada) begin
                    if (cheia) begin
                        erroProx   = 1'b1;
                        estadoProx = PARADO;
                    end else begin
                        empilhar     = 1'b1;
                        ponteiroProx = ponteiro + LARGURA_PP'(1);
                        endProx      = end_alvo;
                    end
                end else if (desvio) begin
                    endProx = end_alvo;
                end else begin
                    endProx = endIncr;
                end
            end
            default: begin
                // PARADO: frozen until reset.
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= OCIOSO;
            endAtual   <= END_RESET;
            ponteiro   <= '0;
            erro_pilha <= 1'b0;
        end else begin
            estado     <= estadoProx;
            endAtual   <= endProx;
            ponteiro   <= ponteiroProx;
            erro_pilha <= erroProx;
        end
    end

    // Return-stack storage; contents need no reset since the pointer guards them.
    always_ff @(posedge clock) begin
        if (empilhar && !reset) pilha[idxPush] <= endIncr;
    end

    assign novoEnd     = endProx;
    assign busca_req   = (estado == BUSCA);
    assign pilha_vazia = vazia;
    assign pilha_cheia = cheia;

endmodule

// File: tb/tb_sequenciador_pc.sv
// Directed bench for sequenciador_pc: sequencing, wrap, call/return, stack
// errors, flag priority, fetch stall and reset.
module tb_sequenciador_pc;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita, habilita2;
    logic       mem_pronta;
    logic       desvio, chamada, retorno, parar;
    logic [7:0] end_alvo;

    logic [7:0] novoEnd, endAtual;
    logic       busca_req, pilha_vazia, pilha_cheia, erro_pilha;
    logic [1:0] estado;

    logic [7:0] novoEnd2, endAtual2;
    logic       busca_req2, pilha_vazia2, pilha_cheia2, erro_pilha2;
    logic [1:0] estado2;

    int passCount = 0;
    int totalCount = 0;

    always #5 clock = ~clock;

    sequenciador_pc dut (
        .clock(clock), .reset(reset), .habilita(habilita), .mem_pronta(mem_pronta),
        .desvio(desvio), .chamada(chamada), .retorno(retorno), .parar(parar),
        .end_alvo(end_alvo), .novoEnd(novoEnd), .endAtual(endAtual),
        .busca_req(busca_req), .estado(estado), .pilha_vazia(pilha_vazia),
        .pilha_cheia(pilha_cheia), .erro_pilha(erro_pilha)
    );

    sequenciador_pc #(.END_RESET(8'hFE)) dutFe (
        .clock(clock), .reset(reset), .habilita(habilita2), .mem_pronta(mem_pronta),
        .desvio(1'b0), .chamada(1'b0), .retorno(1'b0), .parar(1'b0),
        .end_alvo(8'h00), .novoEnd(novoEnd2), .endAtual(endAtual2),
        .busca_req(busca_req2), .estado(estado2), .pilha_vazia(pilha_vazia2),
        .pilha_cheia(pilha_cheia2), .erro_pilha(erro_pilha2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        totalCount++;
        assert (obs === esp) begin
            passCount++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic verificaReset(input string tag);
        verifica({tag, "_estado"}, 32'(estado), 32'd0);
        verifica({tag, "_end"}, 32'(endAtual), 32'h00);
        verifica({tag, "_busca"}, 32'(busca_req), 32'd0);
        verifica({tag, "_erro"}, 32'(erro_pilha), 32'd0);
        verifica({tag, "_vazia"}, 32'(pilha_vazia), 32'd1);
    endtask

    initial begin
        reset = 1'b1; habilita = 1'b0; habilita2 = 1'b0; mem_pronta = 1'b1;
        desvio = 1'b0; chamada = 1'b0; retorno = 1'b0; parar = 1'b0; end_alvo = 8'h00;
        tick(); tick();

        // Reset state
        verificaReset("rst");
        verifica("rst_cheia", 32'(pilha_cheia), 32'd0);
        verifica("rst_novoEnd", 32'(novoEnd), 32'h00);
        verifica("rst_fe_end", 32'(endAtual2), 32'hFE);
        reset = 1'b0;

        // Sequential run, both instances
        habilita = 1'b1; habilita2 = 1'b1;
        tick();
        verifica("seq0_estado", 32'(estado), 32'd1);
        verifica("seq0_busca", 32'(busca_req), 32'd1);
        verifica("seq0_end", 32'(endAtual), 32'h00);
        verifica("fe0_end", 32'(endAtual2), 32'hFE);
        tick();
        verifica("seq0x_busca", 32'(busca_req), 32'd0);
        verifica("seq0x_end", 32'(endAtual), 32'h00);
        verifica("seq0x_novoEnd", 32'(novoEnd), 32'h01);
        tick();
        verifica("seq1_end", 32'(endAtual), 32'h01);
        verifica("seq1_busca", 32'(busca_req), 32'd1);
        verifica("fe1_end", 32'(endAtual2), 32'hFF);
        tick(); tick();
        verifica("seq2_end", 32'(endAtual), 32'h02);
        verifica("fe2_wrap", 32'(endAtual2), 32'h00);
        verifica("fe2_erro", 32'(erro_pilha2), 32'd0);
        habilita2 = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        verifica("seq5_end", 32'(endAtual), 32'h05);

        // Call at 05 then return
        tick();
        chamada = 1'b1; end_alvo = 8'h40;
        #1 verifica("call_novoEnd", 32'(novoEnd), 32'h40);
        tick();
        chamada = 1'b0;
        verifica("call_end", 32'(endAtual), 32'h40);
        verifica("call_vazia", 32'(pilha_vazia), 32'd0);
        tick();
        retorno = 1'b1;
        #1 verifica("ret_novoEnd", 32'(novoEnd), 32'h06);
        tick();
        retorno = 1'b0;
        verifica("ret_end", 32'(endAtual), 32'h06);
        verifica("ret_vazia", 32'(pilha_vazia), 32'd1);

        // Four nested calls fill the stack
        for (int i = 0; i < 4; i++) begin
            tick();
            chamada = 1'b1; end_alvo = 8'h80 + 8'(i);
            tick();
            chamada = 1'b0;
        end
        verifica("full_end", 32'(endAtual), 32'h83);
        verifica("full_cheia", 32'(pilha_cheia), 32'd1);
        // Fifth call overflows
        tick();
        chamada = 1'b1; end_alvo = 8'h90;
        tick();
        chamada = 1'b0;
        verifica("ovf_estado", 32'(estado), 32'd3);
        verifica("ovf_end", 32'(endAtual), 32'h83);
        verifica("ovf_erro", 32'(erro_pilha), 32'd1);
        verifica("ovf_busca", 32'(busca_req), 32'd0);
        desvio = 1'b1; end_alvo = 8'h11;
        tick(); tick();
        desvio = 1'b0;
        verifica("parado_end", 32'(endAtual), 32'h83);
        verifica("parado_estado", 32'(estado), 32'd3);

        // Reset out of PARADO
        reset = 1'b1;
        tick();
        reset = 1'b0;
        verificaReset("rstParado");

        // Return on empty stack
        tick(); tick();
        retorno = 1'b1;
        tick();
        retorno = 1'b0;
        verifica("unf_estado", 32'(estado), 32'd3);
        verifica("unf_end", 32'(endAtual), 32'h00);
        verifica("unf_erro", 32'(erro_pilha), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        verificaReset("rstUnf");

        // parar beats retorno and desvio
        tick(); tick();
        parar = 1'b1; retorno = 1'b1; desvio = 1'b1; end_alvo = 8'h55;
        #1 verifica("prio_novoEnd", 32'(novoEnd), 32'h00);
        tick();
        parar = 1'b0; retorno = 1'b0; desvio = 1'b0;
        verifica("prio_estado", 32'(estado), 32'd3);
        verifica("prio_end", 32'(endAtual), 32'h00);
        verifica("prio_erro", 32'(erro_pilha), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Fetch stall: mem_pronta low for 3 cycles, habilita dropped mid-BUSCA
        mem_pronta = 1'b0;
        tick();
        habilita = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            verifica("stall_busca", 32'(busca_req), 32'd1);
            verifica("stall_end", 32'(endAtual), 32'h00);
            verifica("stall_estado", 32'(estado), 32'd1);
        end
        mem_pronta = 1'b1;
        tick();
        desvio = 1'b1; end_alvo = 8'hA0;
        tick();
        desvio = 1'b0;
        verifica("br_end", 32'(endAtual), 32'hA0);
        verifica("br_estado", 32'(estado), 32'd0);
        habilita = 1'b1;
        tick();
        verifica("br_busca", 32'(busca_req), 32'd1);

        // Reset during BUSCA
        reset = 1'b1;
        tick();
        reset = 1'b0;
        habilita = 1'b0;
        verificaReset("rstBusca");

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
